// File: rtl/iram_prog_controller.sv
`default_nettype none
// ============================================================================
// Module   : iram_prog_controller
// Purpose  : Loads the instruction memory from a framed UART byte stream
//            (16-bit word count, little-endian 32-bit words, XOR checksum)
//            and arbitrates the single IRAM port between fetch and loader.
//            While a load runs, prog_ena holds the fetch stage in reset.
// Ports    : clk, Rst (sync, active high)
//            prog_req              - start-load pulse (honoured only in IDLE)
//            rx_data/rx_valid      - received UART byte, one-cycle valid
//            fetch_en/fetch_addr   - fetch read request (passed through idle)
//            imem_en/we/addr/din   - IRAM port
//            prog_ena              - load in progress
//            prog_done             - one-cycle pulse on a successful load
//            prog_err              - sticky load error
//            word_cnt              - words written in current/last load
// Revision : 1.0 - initial release
// ============================================================================
module iram_prog_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          MAX_WORDS   = 4096,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        prog_req,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fetch_en,
  input  logic [31:0] fetch_addr,
  output logic        imem_en,
  output logic [3:0]  imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        prog_ena,
  output logic        prog_done,
  output logic        prog_err,
  output logic [15:0] word_cnt
);

  localparam logic [31:0] c_tmo_last  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN0   = 3'd1,
    S_LEN1   = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_FINISH = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [31:0] r_word;
  logic [7:0]  r_csum;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_tmo;
  logic        r_err;

  logic [15:0] w_len_full;
  logic        w_len_bad;
  logic [15:0] w_cnt_inc;
  logic [31:0] w_wr_addr;
  logic        w_rx_state;
  logic        w_timeout;

  // Full length as it will be once the high byte is latched in LEN1.
  assign w_len_full = {rx_data, r_len[7:0]};
  assign w_len_bad  = (w_len_full == 16'd0) || ({16'd0, w_len_full} > c_max_words);
  assign w_cnt_inc  = r_word_cnt + 16'd1;
  assign w_wr_addr  = BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
  assign w_rx_state = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timeout  = (r_tmo == c_tmo_last);

  assign prog_err = r_err;
  assign word_cnt = r_word_cnt;

  always_ff @(posedge clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    prog_ena  = (r_state != S_IDLE);
    prog_done = (r_state == S_FINISH);
    imem_en   = 1'b0;
    imem_we   = 4'h0;
    imem_addr = 32'h0;
    imem_din  = 32'h0;

    if (r_state == S_IDLE) begin
      imem_en   = fetch_en;
      imem_addr = fetch_addr;
    end else if (r_state == S_WRITE) begin
      imem_en   = 1'b1;
      imem_we   = 4'hF;
      imem_addr = w_wr_addr;
      imem_din  = r_word;
    end

    // An arriving byte takes priority over a timeout in the same cycle.
    case (r_state)
      S_IDLE:   if (prog_req) w_next = S_LEN0;
      S_LEN0: begin
        if (rx_valid)       w_next = S_LEN1;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_LEN1: begin
        if (rx_valid)       w_next = w_len_bad ? S_ERROR : S_DATA;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_DATA: begin
        if (rx_valid) begin
          if (r_byte_idx == 2'd3) w_next = S_WRITE;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_WRITE:  w_next = (w_cnt_inc == r_len) ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (rx_valid)       w_next = (rx_data == r_csum) ? S_FINISH : S_ERROR;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_FINISH: w_next = S_IDLE;
      S_ERROR:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_len      <= 16'd0;
      r_word_cnt <= 16'd0;
      r_word     <= 32'd0;
      r_csum     <= 8'd0;
      r_byte_idx <= 2'd0;
      r_tmo      <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prog_req) begin
            r_err      <= 1'b0;
            r_word_cnt <= 16'd0;
            r_csum     <= 8'd0;
            r_byte_idx <= 2'd0;
          end
        end
        S_LEN0: if (rx_valid) r_len[7:0]  <= rx_data;
        S_LEN1: if (rx_valid) r_len[15:8] <= rx_data;
        S_DATA: begin
          if (rx_valid) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= rx_data;
            r_csum     <= r_csum ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: r_word_cnt <= w_cnt_inc;
        default: ;
      endcase

      // Inter-byte idle timer: restarts on load start and on each accepted byte.
      if (((r_state == S_IDLE) && prog_req) || (w_rx_state && rx_valid))
        r_tmo <= 32'd0;
      else if (w_rx_state)
        r_tmo <= r_tmo + 32'd1;

      if (w_next == S_ERROR)
        r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iram_prog_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_iram_prog_controller
// Purpose  : Directed and randomized checks of iram_prog_controller against
//            a frame-level reference model (expected writes, done/err flags).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iram_prog_controller;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        Rst;
  logic        prog_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        imem_en;
  logic [3:0]  imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        prog_ena;
  logic        prog_done;
  logic        prog_err;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  iram_prog_controller #(
    .BASE_ADDR   (32'h0),
    .MAX_WORDS   (4096),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .prog_req   (prog_req),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .imem_en    (imem_en),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_din   (imem_din),
    .prog_ena   (prog_ena),
    .prog_done  (prog_done),
    .prog_err   (prog_err),
    .word_cnt   (word_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Monitor: every IRAM access while a load is active is logged; only the
  // expected writes may appear here.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_we_q[$];
  int          done_total = 0;

  always @(negedge clk) begin
    if (prog_ena && imem_en) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_din);
      wr_we_q.push_back(imem_we);
    end
    if (prog_done) done_total++;
  end

  logic [31:0] ld_words[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    step(gap);
  endtask

  function automatic int rgap();
    return int'($urandom_range(2, 5));
  endfunction

  // Sends one complete frame built from len/ld_words and checks the outcome
  // against the frame rules: valid length -> one write per word at
  // BASE+4*i, then done on matching checksum or error otherwise.
  task automatic run_load(input int len, input logic corrupt, input logic inject_req,
                          input string name);
    int          base;
    int          dbase;
    logic        valid;
    logic [7:0]  cs;
    logic [7:0]  v;
    int          nexp;
    logic [15:0] len16;
    len16 = 16'(len);
    base  = wr_addr_q.size();
    dbase = done_total;
    valid = (len >= 1) && (len <= 4096);
    fetch_en   = 1'b1;
    fetch_addr = $urandom;

    prog_req = 1'b1;
    step(1);
    prog_req = 1'b0;
    check({name, "_ena_up"}, {31'd0, prog_ena}, 32'd1);
    check({name, "_err_clr"}, {31'd0, prog_err}, 32'd0);
    check({name, "_mux_block"}, {31'd0, imem_en}, 32'd0);

    send_byte(len16[7:0], rgap());
    send_byte(len16[15:8], valid ? rgap() : 0);
    if (!valid) begin
      check({name, "_len_err"}, {31'd0, prog_err}, 32'd1);
      step(3);
    end else begin
      cs = 8'd0;
      for (int i = 0; i < len; i++) begin
        for (int b = 0; b < 4; b++) begin
          v  = ld_words[i][8*b +: 8];
          cs = cs ^ v;
          send_byte(v, rgap());
          if (inject_req && i == 0 && b == 1) begin
            prog_req = 1'b1;
            step(1);
            prog_req = 1'b0;
          end
        end
      end
      send_byte(corrupt ? (cs ^ 8'h01) : cs, 4);
    end

    nexp = valid ? len : 0;
    check({name, "_nwrites"}, 32'(wr_addr_q.size() - base), 32'(nexp));
    if (wr_addr_q.size() - base == nexp) begin
      for (int i = 0; i < nexp; i++) begin
        check({name, "_addr"}, wr_addr_q[base+i], 32'(4 * i));
        check({name, "_data"}, wr_data_q[base+i], ld_words[i]);
        check({name, "_we"}, {28'd0, wr_we_q[base+i]}, 32'hF);
      end
    end
    check({name, "_done"}, 32'(done_total - dbase), (valid && !corrupt) ? 32'd1 : 32'd0);
    check({name, "_err"}, {31'd0, prog_err}, (!valid || corrupt) ? 32'd1 : 32'd0);
    check({name, "_ena_down"}, {31'd0, prog_ena}, 32'd0);
    check({name, "_word_cnt"}, {16'd0, word_cnt}, 32'(nexp));
    check({name, "_pass_en"}, {31'd0, imem_en}, 32'd1);
    check({name, "_pass_addr"}, imem_addr, fetch_addr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    Rst = 1'b1; prog_req = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    fetch_en = 1'b0; fetch_addr = 32'd0;
    step(2);
    check("rst_ena", {31'd0, prog_ena}, 32'd0);
    check("rst_done", {31'd0, prog_done}, 32'd0);
    check("rst_err", {31'd0, prog_err}, 32'd0);
    check("rst_wcnt", {16'd0, word_cnt}, 32'd0);
    Rst = 1'b0;
    fetch_en = 1'b1; fetch_addr = 32'h40;
    step(1);
    check("pass_en", {31'd0, imem_en}, 32'd1);
    check("pass_addr", imem_addr, 32'h40);
    check("pass_we", {28'd0, imem_we}, 32'd0);
    check("pass_din", imem_din, 32'd0);
    check("pass_ena", {31'd0, prog_ena}, 32'd0);
    fetch_en = 1'b0;
    #1;
    check("pass_en_off", {31'd0, imem_en}, 32'd0);

    // Reference frames
    ld_words[0] = 32'h0000_0013;
    ld_words[1] = 32'h0010_0093;
    run_load(2, 1'b0, 1'b0, "good");
    run_load(2, 1'b1, 1'b0, "badcs");
    run_load(0, 1'b0, 1'b0, "len0");
    run_load(4097, 1'b0, 1'b0, "len4097");

    // Timeout: three data bytes then silence
    base = wr_addr_q.size();
    prog_req = 1'b1; step(1); prog_req = 1'b0;
    send_byte(8'h02, 2);
    send_byte(8'h00, 2);
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 2);
    send_byte(8'hCC, 0);
    step(TMO - 1);
    check("tmo_early", {31'd0, prog_err}, 32'd0);
    step(1);
    check("tmo_err", {31'd0, prog_err}, 32'd1);
    step(3);
    check("tmo_ena", {31'd0, prog_ena}, 32'd0);
    check("tmo_nwrites", 32'(wr_addr_q.size() - base), 32'd0);

    // Ignored prog_req mid-DATA
    ld_words[0] = $urandom; ld_words[1] = $urandom; ld_words[2] = $urandom;
    run_load(3, 1'b0, 1'b1, "inject");

    // Reset in the middle of DATA
    base = wr_addr_q.size();
    fetch_en = 1'b1; fetch_addr = 32'h0000_1234;
    prog_req = 1'b1; step(1); prog_req = 1'b0;
    send_byte(8'h03, 2);
    send_byte(8'h00, 2);
    send_byte(8'h11, 2);
    send_byte(8'h22, 1);
    Rst = 1'b1;
    step(1);
    check("mid_rst_ena", {31'd0, prog_ena}, 32'd0);
    check("mid_rst_done", {31'd0, prog_done}, 32'd0);
    check("mid_rst_err", {31'd0, prog_err}, 32'd0);
    check("mid_rst_wcnt", {16'd0, word_cnt}, 32'd0);
    check("mid_rst_en", {31'd0, imem_en}, 32'd1);
    check("mid_rst_addr", imem_addr, 32'h0000_1234);
    check("mid_rst_we", {28'd0, imem_we}, 32'd0);
    Rst = 1'b0;
    step(2);
    check("mid_rst_nwrites", 32'(wr_addr_q.size() - base), 32'd0);

    // Randomized frames
    for (int it = 0; it < 8; it++) begin
      int   len;
      logic cor;
      logic inj;
      len = int'($urandom_range(1, 6));
      cor = ($urandom_range(0, 3) == 0);
      inj = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 8; k++) ld_words[k] = $urandom;
      run_load(len, cor, inj, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
